// File: rtl/counter_pwm_if.sv
// Counter-sample / duty-handshake / PWM-output bundle for counter_pwm.
// The master drives the upstream count and duty requests; the slave is the PWM block.
interface counter_pwm_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  en;
  logic [DATA_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] duty;
  logic                  duty_valid;
  logic                  duty_ready;
  logic                  pwm_out;
  logic                  period_strobe;

  modport master (
    output en, cnt, duty, duty_valid,
    input  duty_ready, pwm_out, period_strobe
  );

  modport slave (
    input  en, cnt, duty, duty_valid,
    output duty_ready, pwm_out, period_strobe
  );
endinterface

// File: rtl/counter_pwm.sv
// PWM from an external counter, with a double-buffered duty that swaps only at the period boundary.
// Latency: 1 clk from cnt to pwm_out. Backpressure: duty_ready stays low while a duty waits for the boundary.
module counter_pwm #(
  parameter int DATA_WIDTH = 8,
  parameter int COUNT_FROM = 0,
  parameter int COUNT_TO   = 10,
  parameter int POLARITY   = 1
) (
  input logic         clk,
  input logic         rst,
  counter_pwm_if.slave bus
);
  localparam logic [DATA_WIDTH:0] FROM_W = (DATA_WIDTH + 1)'(COUNT_FROM);
  localparam logic [DATA_WIDTH:0] TO_W   = (DATA_WIDTH + 1)'(COUNT_TO);
  localparam logic                POL    = (POLARITY != 0);

  typedef enum logic {EMPTY, PENDING} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] pending_duty;
  logic [DATA_WIDTH-1:0] active_duty;
  logic                  ready;
  logic                  pwm;
  logic                  strobe;

  logic [DATA_WIDTH:0] cnt_w;
  logic [DATA_WIDTH:0] offset;
  logic                in_range;
  logic                raw;
  logic                boundary;

  assign cnt_w    = {1'b0, bus.cnt};
  assign offset   = cnt_w - FROM_W;
  assign in_range = (cnt_w >= FROM_W) && (cnt_w <= TO_W);
  // Out-of-range counts never drive the duty portion, even if offset happens to be small.
  assign raw      = in_range && (offset < {1'b0, active_duty});
  assign boundary = bus.en && (cnt_w == TO_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= EMPTY;
      pending_duty <= '0;
      active_duty  <= '0;
      ready        <= 1'b0;
      pwm          <= ~POL;
      strobe       <= 1'b0;
    end else begin
      strobe <= boundary;
      if (bus.en) begin
        pwm <= raw ~^ POL;
      end
      case (state)
        EMPTY: begin
          if (bus.duty_valid && ready) begin
            pending_duty <= bus.duty;
            state        <= PENDING;
            ready        <= 1'b0;
          end else begin
            ready <= 1'b1;
          end
        end
        PENDING: begin
          if (boundary) begin
            active_duty <= pending_duty;
            state       <= EMPTY;
            ready       <= 1'b1;
          end
        end
        default: begin
          state <= EMPTY;
          ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.duty_ready    = ready;
  assign bus.pwm_out       = pwm;
  assign bus.period_strobe = strobe;
endmodule
